// File: rtl/clk_stop_ctrl.sv
// Clock-stop controller: drains outstanding memory ops after HLT, stops the core
// clock gate, and sequences the resume_n pulse when a wake source appears.
module clk_stop_ctrl #(
   parameter int DRAIN_TIMEOUT = 255,
   parameter int WAKE_CYCLES   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hlt_req,
   input  logic       mem_issue,
   input  logic       mem_done,
   input  logic       intr,
   input  logic       intr_en,
   input  logic       nmi,
   input  logic       ext_resume,
   output logic       stop,
   output logic       resume_n,
   output logic       halted,
   output logic       wake_ack,
   output logic [1:0] wake_cause,
   output logic       hlt_abort,
   output logic       err
);

   typedef enum logic [1:0] {
      S_RUN,
      S_DRAIN,
      S_STOPPED,
      S_WAKE
   } state_t;

   localparam logic [7:0] TMO_LAST  = 8'(DRAIN_TIMEOUT - 1);
   localparam logic [3:0] WAKE_LOAD = 4'(WAKE_CYCLES);

   localparam logic [1:0] CAUSE_NONE = 2'b00;
   localparam logic [1:0] CAUSE_NMI  = 2'b01;
   localparam logic [1:0] CAUSE_INTR = 2'b10;
   localparam logic [1:0] CAUSE_EXT  = 2'b11;

   // Returns {error, new_count}: saturates at 15, floors at 0, flags either bound.
   function automatic logic [4:0] oc_step(input logic [3:0] cur, input logic inc,
                                          input logic dec);
      logic [4:0] r;
      r = {1'b0, cur};
      if (inc && !dec) begin
         if (cur == 4'd15) r[4] = 1'b1;
         else              r[3:0] = cur + 4'd1;
      end else if (dec && !inc) begin
         if (cur == 4'd0) r[4] = 1'b1;
         else             r[3:0] = cur - 4'd1;
      end
      return r;
   endfunction

   state_t     state;
   logic [3:0] oc;
   logic [7:0] drain_tmr;
   logic [3:0] wake_cnt;
   logic [1:0] cause_q;

   logic       wake;
   logic [1:0] wake_src;
   logic [3:0] oc_nxt;
   logic       oc_err;

   always_comb begin
      wake     = nmi | (intr & intr_en) | ext_resume;
      wake_src = CAUSE_NONE;
      if (nmi)                 wake_src = CAUSE_NMI;
      else if (intr & intr_en) wake_src = CAUSE_INTR;
      else if (ext_resume)     wake_src = CAUSE_EXT;
      {oc_err, oc_nxt} = oc_step(oc, mem_issue, mem_done);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_RUN;
         oc         <= 4'd0;
         drain_tmr  <= 8'd0;
         wake_cnt   <= 4'd0;
         cause_q    <= CAUSE_NONE;
         stop       <= 1'b0;
         resume_n   <= 1'b1;
         halted     <= 1'b0;
         wake_ack   <= 1'b0;
         wake_cause <= CAUSE_NONE;
         hlt_abort  <= 1'b0;
         err        <= 1'b0;
      end else begin
         oc         <= oc_nxt;
         wake_ack   <= 1'b0;
         wake_cause <= CAUSE_NONE;
         hlt_abort  <= 1'b0;
         if (oc_err) err <= 1'b1;

         case (state)
            S_RUN: begin
               if (hlt_req) begin
                  state     <= S_DRAIN;
                  drain_tmr <= 8'd0;
               end
            end

            S_DRAIN: begin
               drain_tmr <= drain_tmr + 8'd1;
               // A pending wake cancels the halt even if draining just finished.
               if (wake) begin
                  state     <= S_RUN;
                  hlt_abort <= 1'b1;
               end else if (oc_nxt == 4'd0 && !mem_issue) begin
                  state  <= S_STOPPED;
                  stop   <= 1'b1;
                  halted <= 1'b1;
               end else if (drain_tmr == TMO_LAST) begin
                  state  <= S_STOPPED;
                  stop   <= 1'b1;
                  halted <= 1'b1;
                  err    <= 1'b1;
               end
            end

            S_STOPPED: begin
               if (mem_issue) err <= 1'b1;
               if (wake) begin
                  state    <= S_WAKE;
                  cause_q  <= wake_src;
                  wake_cnt <= WAKE_LOAD;
                  stop     <= 1'b0;
                  resume_n <= 1'b0;
               end
            end

            S_WAKE: begin
               // Runs to completion regardless of the wake level.
               wake_cnt <= wake_cnt - 4'd1;
               if (wake_cnt == 4'd1) begin
                  state      <= S_RUN;
                  resume_n   <= 1'b1;
                  halted     <= 1'b0;
                  wake_ack   <= 1'b1;
                  wake_cause <= cause_q;
               end
            end

            default: state <= S_RUN;
         endcase
      end
   end

endmodule

// File: doc/clk_stop_ctrl.md
CLK_STOP_CTRL -- requirements
Module: clk_stop_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_TIMEOUT, default 255, meaning the maximum DRAIN cycles before a forced stop (range 1..255).
REQ-002 SHALL have parameter WAKE_CYCLES, default 2, meaning the number of cycles resume_n is held low on wake (range 1..15).
REQ-003 SHALL have the following ports:
- clk  in  1  free-running clock, ungated, upstream of the clock gate;
- rst  in  1  reset, synchronous, active-high;
- hlt_req  in  1  one-cycle pulse on HLT retire;
- mem_issue  in  1  a memory op was issued this cycle;
- mem_done  in  1  a memory op completed this cycle;
- intr  in  1  maskable interrupt pending (level);
- intr_en  in  1  EFLAGS.IF;
- nmi  in  1  non-maskable interrupt (level);
- ext_resume  in  1  debug/external resume (level);
- stop  out  1  to gate stop input;
- resume_n  out  1  to gate resume_n input, active-low;
- halted  out  1  core clock stopped;
- wake_ack  out  1  one-cycle pulse on return to RUN;
- wake_cause  out  2  00 none, 01 nmi, 10 intr, 11 ext; valid with wake_ack;
- hlt_abort  out  1  one-cycle pulse when a halt is cancelled in DRAIN;
- err  out  1  sticky error.
REQ-004 All outputs SHALL be driven directly from flops; no combinational input-to-output path.

Function
REQ-005 SHALL keep a 4-bit outstanding count (oc):
- +1 on mem_issue only;
- -1 on mem_done only;
- unchanged when both or neither are asserted.
REQ-006 oc SHALL saturate at 15 on increment; an increment at 15 SHALL set err.
REQ-007 A decrement at oc=0 SHALL leave oc=0 and set err.
REQ-008 wake = nmi | (intr & intr_en) | ext_resume, with cause priority nmi > intr > ext.
REQ-009 SHALL implement FSM states RUN, DRAIN, STOPPED, WAKE.
REQ-010 RUN: stop=0, resume_n=1, halted=0; on hlt_req go to DRAIN next cycle and clear the drain timer.
REQ-011 DRAIN: stop=0, resume_n=1; drain timer (8-bit) increments each cycle.
REQ-012 DRAIN with wake asserted SHALL return to RUN, pulse hlt_abort, and not pulse wake_ack (wake has priority over drain completion).
REQ-013 DRAIN with oc=0 and mem_issue=0 (and no wake) SHALL go to STOPPED next cycle.
REQ-014 DRAIN with drain timer reaching DRAIN_TIMEOUT SHALL set err and go to STOPPED.
REQ-015 STOPPED: stop=1, resume_n=1, halted=1.
REQ-016 In STOPPED, mem_done SHALL still update oc.
REQ-017 In STOPPED, mem_issue SHALL set err.
REQ-018 In STOPPED, wake SHALL go to WAKE, latch wake_cause, and load the wake counter with WAKE_CYCLES.
REQ-019 WAKE: stop=0, resume_n=0, halted=1; the wake counter decrements each cycle; at 1 the FSM goes to RUN.
REQ-020 resume_n SHALL be low exactly WAKE_CYCLES cycles.
REQ-021 On the RUN entry cycle from WAKE, wake_ack=1, halted=0, and wake_cause holds the latched value; wake_cause SHALL be 00 otherwise.
REQ-022 hlt_req in DRAIN, STOPPED or WAKE SHALL be ignored.
REQ-023 hlt_req coincident with wake in RUN SHALL enter DRAIN; REQ-012 then aborts on the following cycle if wake persists.
REQ-024 Wake deasserting during WAKE SHALL NOT shorten the WAKE sequence.
REQ-025 err SHALL clear only on rst.

Reset
REQ-026 On rst=1 at a clk edge:
- state=RUN, oc=0, timers=0;
- stop=0, resume_n=1, halted=0, wake_ack=0, wake_cause=00, hlt_abort=0, err=0.
REQ-027 rst SHALL override all other inputs in any state, including mid-DRAIN and mid-WAKE.
REQ-028 The first post-reset cycle SHALL accept hlt_req.

Verification
REQ-029 Basic halt: oc=0, hlt_req pulse at cycle 0 -> DRAIN at 1, STOPPED at 2 with stop=1, halted=1.
REQ-030 Drain: 3 mem_issue then hlt_req; mem_done at cycles 5, 8, 12 -> stop=1 at cycle 13, err=0.
REQ-031 Wake: in STOPPED, assert intr with intr_en=1 (nmi=0) -> resume_n=0 for 2 cycles, stop=0, then wake_ack=1 with wake_cause=10; intr with intr_en=0 -> stays STOPPED.
REQ-032 Abort: hlt_req with oc=2, nmi asserted 3 cycles later -> hlt_abort pulse, RUN, stop never 1.
REQ-033 Timeout: DRAIN_TIMEOUT=4, oc=1 with no mem_done -> STOPPED 4 cycles after entering DRAIN, err=1 sticky until rst.
REQ-034 Reset mid-WAKE: rst during the first resume_n=0 cycle -> next cycle resume_n=1, stop=0, halted=0, state RUN.
